// File: rtl/conv_enc_tx.sv
// conv_enc_tx
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) for the transmit
// end of the Viterbi link. Information bits arrive framed on one valid/ready
// port; one 2-bit code symbol per bit leaves on a second valid/ready port.
// Each frame is closed with two zero tail bits so the trellis ends in s0.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   bit_valid_i   input bit valid
//   bit_i         information bit
//   bit_last_i    final information bit of the frame (sampled with bit_i)
//   bit_ready_o   encoder accepts a bit this cycle
//   sym_valid_o   code symbol valid
//   sym_o         code symbol {g0,g1}
//   sym_last_o    final tail symbol of the frame
//   sym_ready_i   downstream accepts the symbol
//   frame_done_o  one-cycle pulse the cycle after the last tail symbol handshake
//   dbg_state_o   current FSM state (0=DATA, 1=TAIL1, 2=TAIL2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload stable until that edge; ready
// never depends combinationally on the valid of the same port.

module conv_enc_tx (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bit_valid_i,
    input  logic       bit_i,
    input  logic       bit_last_i,
    output logic       bit_ready_o,
    output logic       sym_valid_o,
    output logic [1:0] sym_o,
    output logic       sym_last_o,
    input  logic       sym_ready_i,
    output logic       frame_done_o,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_TAIL1 = 2'd1,
        ST_TAIL2 = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] sr;        // {u(k-1), u(k-2)}, equals the trellis state
    logic       slot_free; // output register empty or being drained this edge
    logic       accept;
    logic       enc_u;
    logic [1:0] enc_sym;

    assign slot_free   = !sym_valid_o || sym_ready_i;
    assign bit_ready_o = (state == ST_DATA) && slot_free;
    assign accept      = bit_valid_i && bit_ready_o;
    assign dbg_state_o = state;

    // Tail states always encode a zero; bit_i is only looked at in DATA.
    assign enc_u   = (state == ST_DATA) ? bit_i : 1'b0;
    assign enc_sym = {enc_u ^ sr[1] ^ sr[0], enc_u ^ sr[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_DATA;
            sr           <= 2'b00;
            sym_o        <= 2'b00;
            sym_valid_o  <= 1'b0;
            sym_last_o   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= sym_valid_o && sym_ready_i && sym_last_o;

            // Drain on handshake; a load below in the same cycle overrides this.
            if (sym_valid_o && sym_ready_i) begin
                sym_valid_o <= 1'b0;
                sym_last_o  <= 1'b0;
            end

            case (state)
                ST_DATA: begin
                    if (accept) begin
                        sym_o       <= enc_sym;
                        sym_valid_o <= 1'b1;
                        sym_last_o  <= 1'b0;
                        sr          <= {enc_u, sr[1]};
                        if (bit_last_i) begin
                            state <= ST_TAIL1;
                        end
                    end
                end
                ST_TAIL1: begin
                    if (slot_free) begin
                        sym_o       <= enc_sym;
                        sym_valid_o <= 1'b1;
                        sym_last_o  <= 1'b0;
                        sr          <= {1'b0, sr[1]};
                        state       <= ST_TAIL2;
                    end
                end
                ST_TAIL2: begin
                    if (slot_free) begin
                        sym_o       <= enc_sym;
                        sym_valid_o <= 1'b1;
                        sym_last_o  <= 1'b1;
                        // Two zero shifts already give 00; forcing it keeps a
                        // corrupted register from leaking into the next frame.
                        sr          <= 2'b00;
                        state       <= ST_DATA;
                    end
                end
                default: begin
                    state <= ST_DATA;
                end
            endcase
        end
    end

endmodule
